fop_share_arbiter: RTL

- Responder-side sharing block for one pipelined FloPoCo-style operator core (fmul/fadd, ports clk/ce/X/Y/R).
- Accepts operand requests from N_CLIENTS datapath clients, such as fmac instances, and grants one request per cycle in round-robin order.
- Issues each granted request to the core, tracks the client ID through the core latency, and returns the result to the originating client.
- Sits between generated datapath modules and a single shared operator instance.

---
 rtl/fop_share_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fop_share_arbiter.sv
// -----------------------------------------------------------------------------
// fop_share_arbiter
//
// Shares one pipelined FloPoCo-style operator core (ports clk/ce/X/Y/R) between
// N_CLIENTS datapath requesters. It grants one request per cycle in round-robin
// order and registers the granted operands into the core. The client ID rides
// alongside the core in a ce-gated tag pipe. Each result is returned as a
// registered one-cycle pulse to the client that issued it.
//
// Parameters
//   PRECISION  operand/result width in bits
//   N_CLIENTS  number of requesters (2..16)
//   LATENCY    core pipeline depth in ce-enabled edges (1..8); must match core
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        per-client request, held high until granted
//   req_x/y    client i operands at bits [i*PRECISION +: PRECISION]
//   grant      combinational one-hot grant; operands sampled on the next edge
//   op_x/y     registered operands to the core
//   op_ce      core clock enable, high only while something is in flight
//   op_r       core result
//   rsp_valid  one-cycle pulse to the originating client
//   rsp_r      registered result, valid while any rsp_valid bit is high
//
// Optional feature (macro FOP_SHARE_ARB_STATS_EN)
//   contention_cnt  saturating count of cycles with two or more requests
// -----------------------------------------------------------------------------
module fop_share_arbiter #(
   parameter int PRECISION = 16,
   parameter int N_CLIENTS = 4,
   parameter int LATENCY   = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N_CLIENTS-1:0]           req,
   input  logic [N_CLIENTS*PRECISION-1:0] req_x,
   input  logic [N_CLIENTS*PRECISION-1:0] req_y,
   output logic [N_CLIENTS-1:0]           grant,
   output logic [PRECISION-1:0]           op_x,
   output logic [PRECISION-1:0]           op_y,
   output logic                           op_ce,
   input  logic [PRECISION-1:0]           op_r,
   output logic [N_CLIENTS-1:0]           rsp_valid,
   output logic [PRECISION-1:0]           rsp_r
`ifdef FOP_SHARE_ARB_STATS_EN
   ,
   output logic [31:0]                    contention_cnt
`endif
);

   localparam int ID_W = $clog2(N_CLIENTS);

   // Tag stages 1..LATENCY-1 live in bits [LATENCY-2:0]; bit LATENCY-1 is the
   // final stage whose result is on op_r.
   localparam logic [LATENCY-1:0] MID_MASK = {LATENCY{1'b1}} >> 1;

   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    gnt_id;
   logic [ID_W-1:0]    ptr_next;
   logic               gnt_found;
   logic               gnt_valid;

   logic               issue_v;
   logic [ID_W-1:0]    issue_id;

   logic [LATENCY-1:0] tag_v;
   logic [ID_W-1:0]    tag_id [LATENCY];

   // ---------------------------------------------------------------------------
   // Round-robin search starting at ptr, wrapping modulo N_CLIENTS.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here gets a default first so no path can
      // leave it unassigned and infer a latch.
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int k = 0; k < N_CLIENTS; k++) begin
         logic [ID_W-1:0] idx;
         idx = ID_W'((int'(ptr) + k) % N_CLIENTS);
         if (!gnt_found && req[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = idx;
         end
      end
   end

   assign gnt_valid = gnt_found & ~reset;
   assign grant     = gnt_valid ? (N_CLIENTS'(1) << gnt_id) : '0;
   assign ptr_next  = (gnt_id == ID_W'(N_CLIENTS - 1)) ? '0 : gnt_id + 1'b1;

   // The core only advances while an op sits in the issue register or in a tag
   // stage short of the last; reset freezes it so dropped ops go nowhere.
   assign op_ce = (issue_v | (|(tag_v & MID_MASK))) & ~reset;

   // ---------------------------------------------------------------------------
   // Issue stage: operands and owner ID for the core.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state is written with non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         ptr      <= '0;
         op_x     <= '0;
         op_y     <= '0;
         issue_v  <= 1'b0;
         issue_id <= '0;
      end else begin
         issue_v <= gnt_valid;
         if (gnt_valid) begin
            ptr      <= ptr_next;
            op_x     <= req_x[gnt_id*PRECISION +: PRECISION];
            op_y     <= req_y[gnt_id*PRECISION +: PRECISION];
            issue_id <= gnt_id;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Tag pipe valids: shift in lockstep with the core. The final stage is
   // consumed by the response register even on edges where the core is frozen;
   // then the middle stages are already empty, so masking them keeps only the
   // clear of the last stage.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_v <= '0;
      end else if (op_ce) begin
         tag_v <= (tag_v << 1) | LATENCY'(issue_v);
      end else begin
         tag_v <= tag_v & MID_MASK;
      end
   end

   // NOTE: the ID storage needs no reset; an ID is only ever read while its
   // matching valid bit, which is reset, is set.
   always_ff @(posedge clk) begin
      if (op_ce) begin
         tag_id[0] <= issue_id;
         for (int s = 1; s < LATENCY; s++) begin
            tag_id[s] <= tag_id[s-1];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Response register: result and one-hot owner pulse.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_r     <= '0;
      end else if (tag_v[LATENCY-1]) begin
         rsp_valid <= N_CLIENTS'(1) << tag_id[LATENCY-1];
         rsp_r     <= op_r;
      end else begin
         rsp_valid <= '0;
      end
   end

`ifdef FOP_SHARE_ARB_STATS_EN
   // Cycles with two or more simultaneous requests, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         contention_cnt <= '0;
      end else if (($countones(req) >= 2) && (contention_cnt != '1)) begin
         contention_cnt <= contention_cnt + 32'd1;
      end
   end
`endif

endmodule
